// File: rtl/ysyx_24100012_pkg.sv
// Shared types and constants for the NPC program-counter sequencer.
// Optional misaligned-target trap: define YSYX_24100012_MISALIGN_TRAP_EN.
package ysyx_24100012_pkg;

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_WAIT_INST = 2'd1,
    S_EXEC      = 2'd2,
    S_HALT      = 2'd3
  } state_e;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24100012_pc_ctrl_if.sv
// IFU fetch / EXU start-done handshake bundle of the PC sequencer.
// master = PC sequencer side, slave = IFU/EXU/branch-unit side.
interface ysyx_24100012_pc_ctrl_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_WIDTH-1:0] ifu_req_addr;
  logic                  ifu_rsp_valid;
  logic                  exu_start;
  logic                  exu_done;
  logic                  pc_sel;
  logic [ADDR_WIDTH-1:0] br_target;
  logic                  halt_req;

  modport master (
    output ifu_req_valid,
    output ifu_req_addr,
    output exu_start,
    input  ifu_req_ready,
    input  ifu_rsp_valid,
    input  exu_done,
    input  pc_sel,
    input  br_target,
    input  halt_req
  );

  modport slave (
    input  ifu_req_valid,
    input  ifu_req_addr,
    input  exu_start,
    output ifu_req_ready,
    output ifu_rsp_valid,
    output exu_done,
    output pc_sel,
    output br_target,
    output halt_req
  );

endinterface

// File: rtl/ysyx_24100012_next_pc.sv
// Next-PC selection: PC+4 or halfword-aligned branch target.
// YSYX_24100012_MISALIGN_TRAP_EN redirects word-misaligned targets to mtvec.
module ysyx_24100012_next_pc
  import ysyx_24100012_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  pc_sel_i,
  input  logic [ADDR_WIDTH-1:0] br_target_i,
  input  logic [ADDR_WIDTH-1:0] mtvec_i,
  output logic [ADDR_WIDTH-1:0] npc_o,
  output logic                  misalign_o
);

  logic [ADDR_WIDTH-1:0] seq_pc;
  logic [ADDR_WIDTH-1:0] tgt_pc;
  logic                  unused_bits;

  assign seq_pc = pc_i + ADDR_WIDTH'(INST_BYTES);
  assign tgt_pc = {br_target_i[ADDR_WIDTH-1:1], 1'b0};
  assign unused_bits = ^{mtvec_i, br_target_i[0]};

`ifdef YSYX_24100012_MISALIGN_TRAP_EN
  assign misalign_o = pc_sel_i & br_target_i[1];

  always_comb begin
    npc_o = seq_pc;
    if (misalign_o) begin
      npc_o = {mtvec_i[ADDR_WIDTH-1:2], 2'b00};
    end else if (pc_sel_i) begin
      npc_o = tgt_pc;
    end
  end
`else
  assign misalign_o = 1'b0;
  assign npc_o = pc_sel_i ? tgt_pc : seq_pc;
`endif

endmodule

// File: rtl/ysyx_24100012_pc_ctrl.sv
// PC sequencer: fetch -> wait inst -> exec -> next PC, retire count, halt.
// Optional trap on misaligned target: YSYX_24100012_MISALIGN_TRAP_EN.
module ysyx_24100012_pc_ctrl
  import ysyx_24100012_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ysyx_24100012_pc_ctrl_if.master bus,
  input  logic [ADDR_WIDTH-1:0] mtvec,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  trap,
  output logic                  halted,
  output logic [DATA_WIDTH-1:0] instret
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instret_q, instret_d;
  logic                  trap_q, trap_d;
  logic                  halted_q, halted_d;
  logic                  start_q, start_d;
  logic [ADDR_WIDTH-1:0] npc;
  logic                  misalign;

  ysyx_24100012_next_pc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_pc (
    .pc_i        (pc_q),
    .pc_sel_i    (bus.pc_sel),
    .br_target_i (bus.br_target),
    .mtvec_i     (mtvec),
    .npc_o       (npc),
    .misalign_o  (misalign)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    trap_d    = 1'b0;
    halted_d  = halted_q;
    start_d   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (bus.ifu_req_ready) state_d = S_WAIT_INST;
      end
      S_WAIT_INST: begin
        if (bus.ifu_rsp_valid) begin
          state_d = S_EXEC;
          start_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (bus.exu_done) begin
          pc_d    = npc;
          state_d = S_FETCH;
          // a trapped instruction neither retires nor honours halt
          if (misalign) begin
            trap_d = 1'b1;
          end else begin
            instret_d = instret_q + 1'b1;
            if (bus.halt_req) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end
          end
        end
      end
      S_HALT: begin
        halted_d = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instret_q <= '0;
      trap_q    <= 1'b0;
      halted_q  <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      halted_q  <= halted_d;
      start_q   <= start_d;
    end
  end

  assign bus.ifu_req_valid = (state_q == S_FETCH);
  assign bus.ifu_req_addr  = pc_q;
  assign bus.exu_start     = start_q;
  assign pc      = pc_q;
  assign trap    = trap_q;
  assign halted  = halted_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_ysyx_24100012_pc_ctrl.sv
// Randomized self-checking bench for ysyx_24100012_pc_ctrl.
// Build with YSYX_24100012_MISALIGN_TRAP_EN to cover the trap path.
module tb_ysyx_24100012_pc_ctrl;

`ifdef YSYX_24100012_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] mtvec;
  logic [31:0] pc;
  logic        trap;
  logic        halted;
  logic [31:0] instret;

  ysyx_24100012_pc_ctrl_if bus ();

  ysyx_24100012_pc_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .mtvec   (mtvec),
    .pc      (pc),
    .trap    (trap),
    .halted  (halted),
    .instret (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic        exp_halt;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    exp_pc   = RST_PC;
    exp_ret  = 0;
    exp_halt = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    bus.exu_done      = 1'b0;
    bus.pc_sel        = 1'b0;
    bus.br_target     = '0;
    bus.halt_req      = 1'b0;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!bus.ifu_req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_valid", bus.ifu_req_valid, 1);
    chk("req_addr", bus.ifu_req_addr, exp_pc);
  endtask

  task automatic to_exec(input int rdy_w, input int rsp_w);
    wait_fetch();
    repeat (rdy_w) begin
      bus.ifu_req_ready = 1'b0;
      bus.ifu_rsp_valid = 1'b1;
      @(negedge clk);
      chk("stall_valid", bus.ifu_req_valid, 1);
      chk("stall_addr", bus.ifu_req_addr, exp_pc);
    end
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_req_ready = 1'b1;
    @(negedge clk);
    bus.ifu_req_ready = 1'b0;
    chk("fetch_drop", bus.ifu_req_valid, 0);
    repeat (rsp_w) begin
      bus.exu_done = 1'b1;
      bus.halt_req = 1'b1;
      @(negedge clk);
      chk("early_start", bus.exu_start, 0);
    end
    bus.exu_done      = 1'b0;
    bus.halt_req      = 1'b0;
    bus.ifu_rsp_valid = 1'b1;
    @(negedge clk);
    bus.ifu_rsp_valid = 1'b0;
    chk("exu_start", bus.exu_start, 1);
  endtask

  task automatic run_inst(input bit sel, input logic [31:0] tgt,
                          input bit hlt, input int rdy_w,
                          input int rsp_w, input int done_w);
    bit tr;
    to_exec(rdy_w, rsp_w);
    repeat (done_w) begin
      bus.ifu_rsp_valid = 1'b1;
      @(negedge clk);
      chk("start_pulse", bus.exu_start, 0);
    end
    bus.ifu_rsp_valid = 1'b0;
    bus.exu_done  = 1'b1;
    bus.pc_sel    = sel;
    bus.br_target = tgt;
    bus.halt_req  = hlt;
    @(negedge clk);
    idle_inputs();
    tr = TRAP_EN && sel && tgt[1];
    if (tr) begin
      exp_pc = mtvec & 32'hFFFF_FFFC;
    end else begin
      exp_pc  = sel ? (tgt & 32'hFFFF_FFFE) : exp_pc + 32'd4;
      exp_ret = exp_ret + 1;
      if (hlt) exp_halt = 1'b1;
    end
    chk("pc", pc, exp_pc);
    chk("instret", instret, exp_ret);
    chk("trap", trap, tr);
    chk("halted", halted, exp_halt);
    chk("next_valid", bus.ifu_req_valid, !exp_halt);
    chk("start_end", bus.exu_start, 0);
  endtask

  initial begin
    int t0;
    logic [31:0] hold_pc;
    idle_inputs();
    mtvec = 32'h8000_1003;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instret", instret, 0);
    chk("rst_halted", halted, 0);
    chk("rst_trap", trap, 0);
    chk("rst_start", bus.exu_start, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_valid", bus.ifu_req_valid, 1);

    t0 = cyc;
    run_inst(0, 0, 0, 0, 0, 0);
    chk("period", cyc - t0, 3);
    chk("second_addr", bus.ifu_req_addr, 32'h8000_0004);

    run_inst(0, 0, 0, 4, 1, 2);
    run_inst(1, 32'h8000_0101, 0, 0, 0, 0);
    chk("br_pc", pc, 32'h8000_0100);
    run_inst(1, 32'hFFFF_FFFD, 0, 1, 0, 0);
    run_inst(0, 0, 0, 0, 0, 1);
    chk("wrap_pc", pc, 32'h0000_0000);

    for (int i = 0; i < 40; i++) begin
      run_inst($urandom_range(0, 1), $urandom, 0,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3));
    end

    if (TRAP_EN) begin
      t0 = int'(exp_ret);
      run_inst(1, 32'h8000_0006, 1, 0, 0, 0);
      chk("trap_pc", pc, 32'h8000_1000);
      chk("trap_ret", instret, t0);
      @(negedge clk);
      chk("trap_pulse", trap, 0);
    end

    to_exec(0, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_pc", pc, RST_PC);
    chk("mid_rst_ret", instret, 0);
    chk("mid_rst_start", bus.exu_start, 0);
    chk("mid_rst_halt", halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", bus.ifu_req_valid, 1);
    chk("post_rst_addr", bus.ifu_req_addr, RST_PC);

    run_inst(0, 0, 0, 0, 0, 0);
    run_inst(1, 32'h8000_0040, 1, 0, 0, 1);
    hold_pc = pc;
    for (int i = 0; i < 20; i++) begin
      bus.ifu_req_ready = 1'b1;
      bus.ifu_rsp_valid = 1'($urandom);
      bus.exu_done      = 1'($urandom);
      bus.halt_req      = 1'($urandom);
      bus.pc_sel        = 1'($urandom);
      bus.br_target     = $urandom;
      @(negedge clk);
      chk("halt_valid", bus.ifu_req_valid, 0);
      chk("halt_flag", halted, 1);
      chk("halt_pc", pc, hold_pc);
      chk("halt_ret", instret, exp_ret);
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
